// File: rtl/uc_pkg.sv
// Shared definitions for the microc control unit: opcodes, FSM states and
// the control-word bundle passed from the decoder to the top level.
package uc_pkg;

    // Opcode constants. LI is a class (10xxxx); OP_LI is its canonical form.
    localparam logic [5:0] OP_LI   = 6'b100000;
    localparam logic [5:0] OP_J    = 6'b110000;
    localparam logic [5:0] OP_JZ   = 6'b110001;
    localparam logic [5:0] OP_JNZ  = 6'b110010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    // FSM states; encoding 2'b11 is illegal and recovers to EJEC.
    typedef enum logic [1:0] {
        EJEC    = 2'b00,
        PARADA  = 2'b01,
        REANUDA = 2'b10
    } state_t;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op;
    } ctrl_t;

    // PC+1 with every write disabled: NOPs, resume step and reset.
    localparam ctrl_t CTRL_STEP = '{s_inc: 1'b1, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: 3'b000};
    // PC reloads the jump address with every write disabled: HALT / PARADA.
    localparam ctrl_t CTRL_HOLD = '{s_inc: 1'b0, s_inm: 1'b0, we3: 1'b0, wez: 1'b0, op: 3'b000};

endpackage

// File: rtl/uc_deco.sv
// Purely combinational opcode-to-control decoder. HALT decodes as a NOP
// here; the top level overrides it.
module uc_deco
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl
);

    // Instruction class decode; unknown 11xxxx opcodes fall through as NOP.
    always_comb begin
        ctrl = CTRL_STEP;
        if (opcode[5] == 1'b0) begin
            ctrl.we3 = 1'b1;
            ctrl.wez = 1'b1;
            ctrl.op  = opcode[4:2];
        end else if (opcode[4] == 1'b0) begin
            ctrl.s_inm = 1'b1;
            ctrl.we3   = 1'b1;
        end else begin
            case (opcode)
                OP_J:    ctrl.s_inc = 1'b0;
                OP_JZ:   ctrl.s_inc = ~z;
                OP_JNZ:  ctrl.s_inc = z;
                default: ctrl.s_inc = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uc.sv
// microc control unit: decoder plus HALT/resume FSM and a saturating
// retired-instruction counter.
//
// state   | meaning
// EJEC    | normal execution, outputs from the decoder
// PARADA  | halted, PC reloads the HALT address every cycle
// REANUDA | one-cycle resume step, PC moves past the HALT
module uc
    import uc_pkg::*;
#(
    parameter int W_CNT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Opcode,
    input  logic             z,
    input  logic             continuar,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       Op,
    output logic             parado,
    output logic [W_CNT-1:0] n_instr
);

    state_t             state_q, state_d;
    logic [W_CNT-1:0]   n_instr_q, n_instr_d;
    ctrl_t              deco_ctrl;
    ctrl_t              ctrl;
    logic               parado_c;
    logic               retire;

    uc_deco u_deco (
        .opcode (Opcode),
        .z      (z),
        .ctrl   (deco_ctrl)
    );

    // Next state, HALT override mux and retire strobe; reset forces safe controls.
    always_comb begin
        state_d  = state_q;
        ctrl     = deco_ctrl;
        parado_c = 1'b0;
        retire   = 1'b0;
        case (state_q)
            EJEC: begin
                if (Opcode == OP_HALT) begin
                    ctrl    = CTRL_HOLD;
                    state_d = PARADA;
                end else begin
                    retire = 1'b1;
                end
            end
            PARADA: begin
                ctrl     = CTRL_HOLD;
                parado_c = 1'b1;
                if (continuar) begin
                    state_d = REANUDA;
                end
            end
            REANUDA: begin
                ctrl    = CTRL_STEP;
                retire  = 1'b1;
                state_d = EJEC;
            end
            default: begin
                ctrl    = CTRL_STEP;
                state_d = EJEC;
            end
        endcase
        if (reset) begin
            ctrl     = CTRL_STEP;
            parado_c = 1'b0;
        end
    end

    // Saturating increment of the retired-instruction count.
    always_comb begin
        n_instr_d = n_instr_q;
        if (retire && (n_instr_q != {W_CNT{1'b1}})) begin
            n_instr_d = n_instr_q + W_CNT'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EJEC;
            n_instr_q <= '0;
        end else begin
            state_q   <= state_d;
            n_instr_q <= n_instr_d;
        end
    end

    assign s_inc   = ctrl.s_inc;
    assign s_inm   = ctrl.s_inm;
    assign we3     = ctrl.we3;
    assign wez     = ctrl.wez;
    assign Op      = ctrl.op;
    assign parado  = parado_c;
    assign n_instr = n_instr_q;

endmodule

// File: tb/tb_uc.sv
// Self-checking bench for uc with a behavioural model of the instruction
// stream (running / halted / resuming) and a saturating retire count.
module tb_uc;

    localparam int W = 4;
    localparam int CNT_MAX = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [5:0]   Opcode = 6'b000000;
    logic         z = 1'b0;
    logic         continuar = 1'b0;
    logic         s_inc, s_inm, we3, wez, parado;
    logic [2:0]   Op;
    logic [W-1:0] n_instr;

    int vecs = 0;
    int errs = 0;

    // Model: 0 = running, 1 = halted, 2 = resuming.
    int m_mode = 0;
    int m_cnt  = 0;

    logic [7:0] got;
    logic [7:0] exp;

    uc #(.W_CNT(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .Opcode    (Opcode),
        .z         (z),
        .continuar (continuar),
        .s_inc     (s_inc),
        .s_inm     (s_inm),
        .we3       (we3),
        .wez       (wez),
        .Op        (Op),
        .parado    (parado),
        .n_instr   (n_instr)
    );

    always #5 clk = ~clk;

    assign got = {s_inc, s_inm, we3, wez, Op, parado};

    // Expected {s_inc, s_inm, we3, wez, Op, parado} from the instruction rules.
    function automatic logic [7:0] exp_ctrl(logic [5:0] opc, logic zz, int mode, logic rst);
        logic       inc = 1'b1;
        logic       inm = 1'b0;
        logic       w3  = 1'b0;
        logic       wz  = 1'b0;
        logic [2:0] op  = 3'b000;
        if (rst)        return 8'b1000_0000;
        if (mode == 1)  return 8'b0000_0001;
        if (mode == 2)  return 8'b1000_0000;
        if (opc == 6'd63) return 8'b0000_0000;
        if (opc < 6'd32) begin
            w3 = 1'b1; wz = 1'b1; op = opc[4:2];
        end else if (opc < 6'd48) begin
            inm = 1'b1; w3 = 1'b1;
        end else if (opc == 6'd48) begin
            inc = 1'b0;
        end else if (opc == 6'd49) begin
            inc = ~zz;
        end else if (opc == 6'd50) begin
            inc = zz;
        end
        return {inc, inm, w3, wz, op, 1'b0};
    endfunction

    function automatic int sat_inc(int c);
        return (c < CNT_MAX) ? c + 1 : CNT_MAX;
    endfunction

    // Advance the model across one rising edge with the current inputs.
    task automatic model_edge();
        if (reset) begin
            m_mode = 0; m_cnt = 0;
        end else if (m_mode == 0) begin
            if (Opcode == 6'd63) m_mode = 1;
            else m_cnt = sat_inc(m_cnt);
        end else if (m_mode == 1) begin
            if (continuar) m_mode = 2;
        end else begin
            m_cnt = sat_inc(m_cnt);
            m_mode = 0;
        end
    endtask

    // Drive inputs just after an edge and wait to mid-cycle for sampling.
    task automatic drive(logic [5:0] opc, logic zz, logic cont);
        Opcode = opc; z = zz; continuar = cont;
        @(negedge clk);
        exp = exp_ctrl(Opcode, z, m_mode, reset);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_mode = 0; m_cnt = 0;
    endtask

    task automatic test_reset();
        drive(6'b000100, 1'b0, 1'b1);
        vecs++;
        if (got !== 8'b1000_0000) begin
            $display("FAIL reset_ctrl got=%b exp=%b", got, 8'b1000_0000); errs++;
        end
        vecs++;
        if (n_instr !== W'(0)) begin
            $display("FAIL reset_cnt got=%0d exp=0", n_instr); errs++;
        end
        tick();
        reset = 1'b0;
        m_mode = 0; m_cnt = 0;
    endtask

    task automatic test_li_alu();
        drive(6'b100000, 1'b0, 1'b0);
        vecs++;
        if ({s_inc, s_inm, we3, wez} !== 4'b1110) begin
            $display("FAIL li_ctrl got=%b exp=1110", {s_inc, s_inm, we3, wez}); errs++;
        end
        tick();
        drive(6'b001000, 1'b0, 1'b0);
        vecs++;
        if ({s_inm, wez, Op} !== 5'b01010) begin
            $display("FAIL alu_ctrl got=%b exp=01010", {s_inm, wez, Op}); errs++;
        end
        tick();
        drive(6'b110011, 1'b0, 1'b0);
        vecs++;
        if (n_instr !== W'(2)) begin
            $display("FAIL li_alu_cnt got=%0d exp=2", n_instr); errs++;
        end
        tick();
    endtask

    task automatic test_branches();
        logic [5:0] opcs [4] = '{6'b110001, 6'b110001, 6'b110010, 6'b110010};
        logic       zs   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0] want [4] = '{3'b000, 3'b100, 3'b100, 3'b000};
        for (int i = 0; i < 4; i++) begin
            drive(opcs[i], zs[i], 1'b0);
            vecs++;
            if ({s_inc, we3, wez} !== want[i]) begin
                $display("FAIL branch_%0d got=%b exp=%b", i, {s_inc, we3, wez}, want[i]); errs++;
            end
            tick();
        end
    endtask

    task automatic test_halt();
        int c0;
        c0 = m_cnt;
        for (int i = 0; i < 5; i++) begin
            drive(6'b111111, 1'b0, 1'b0);
            vecs++;
            if (s_inc !== 1'b0 || parado !== (i > 0) || we3 !== 1'b0 || wez !== 1'b0) begin
                $display("FAIL halt_cyc%0d got s_inc=%b parado=%b we3=%b wez=%b", i, s_inc, parado, we3, wez);
                errs++;
            end
            tick();
        end
        drive(6'b111111, 1'b0, 1'b1);
        vecs++;
        if (n_instr !== W'(c0)) begin
            $display("FAIL halt_cnt got=%0d exp=%0d", n_instr, c0); errs++;
        end
        tick();
        drive(6'b111111, 1'b0, 1'b0);
        vecs++;
        if (got !== 8'b1000_0000) begin
            $display("FAIL reanuda_ctrl got=%b exp=%b", got, 8'b1000_0000); errs++;
        end
        tick();
        drive(6'b000000, 1'b0, 1'b1);
        vecs++;
        if (got !== exp || parado !== 1'b0 || n_instr !== W'(c0 + 1)) begin
            $display("FAIL resume_ejec got=%b/%0d exp=%b/%0d", got, n_instr, exp, c0 + 1); errs++;
        end
        tick();
    endtask

    task automatic test_async_reset();
        drive(6'b010000, 1'b0, 1'b0);
        tick();
        drive(6'b111111, 1'b0, 1'b0);
        tick();
        drive(6'b111111, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        #2;
        vecs++;
        if (parado !== 1'b0 || n_instr !== W'(0) || we3 !== 1'b0 || wez !== 1'b0 || s_inc !== 1'b1) begin
            $display("FAIL async_reset got parado=%b cnt=%0d we3=%b wez=%b s_inc=%b exp 0 0 0 0 1",
                     parado, n_instr, we3, wez, s_inc);
            errs++;
        end
        m_mode = 0; m_cnt = 0;
        tick();
        reset = 1'b0;
        drive(6'b001100, 1'b0, 1'b0);
        vecs++;
        if (got !== exp) begin
            $display("FAIL after_reset got=%b exp=%b", got, exp); errs++;
        end
        tick();
    endtask

    task automatic test_nop();
        int c0;
        c0 = m_cnt;
        drive(6'b110111, 1'b1, 1'b1);
        vecs++;
        if ({s_inc, we3, wez} !== 3'b100) begin
            $display("FAIL nop_ctrl got=%b exp=100", {s_inc, we3, wez}); errs++;
        end
        tick();
        drive(6'b000000, 1'b0, 1'b0);
        vecs++;
        if (n_instr !== W'(sat_inc(c0))) begin
            $display("FAIL nop_cnt got=%0d exp=%0d", n_instr, sat_inc(c0)); errs++;
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < (1 << W) + 3; i++) begin
            drive(6'b000100, 1'b0, 1'b0);
            tick();
        end
        drive(6'b000100, 1'b0, 1'b0);
        vecs++;
        if (n_instr !== W'(CNT_MAX)) begin
            $display("FAIL saturate got=%0d exp=%0d", n_instr, CNT_MAX); errs++;
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0] opc;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) opc = 6'b111111;
            else opc = 6'($urandom_range(0, 63));
            drive(opc, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
            vecs++;
            if (got !== exp || n_instr !== W'(m_cnt)) begin
                $display("FAIL random_%0d opc=%b got=%b/%0d exp=%b/%0d", i, opc, got, n_instr, exp, m_cnt);
                errs++;
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_li_alu();
        test_branches();
        test_halt();
        test_async_reset();
        test_nop();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
